// File: rtl/demux_sched_pkg.sv
// ============================================================================
//  Module   : demux_sched_pkg
//  Brief    : Shared types and helpers for the round-robin demux scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2
  } state_t;

  // Wide enough to hold the count value BURST_LEN itself (max 255).
  localparam int BEAT_CNT_W = 8;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_next_sel.sv
// ============================================================================
//  Module   : rr_next_sel
//  Brief    : Combinational round-robin search for the next enabled channel,
//             starting at cur_sel+1 and wrapping back round to cur_sel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_next_sel #(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_OUT-1:0] chan_en,
  input  logic [SEL_W-1:0]   cur_sel,
  output logic [SEL_W-1:0]   next_sel,
  output logic               found
);

  logic [SEL_W-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    next_sel = cur_sel;
    found    = 1'b0;
    w_idx    = '0;
    for (int i = NUM_OUT; i >= 1; i--) begin
      w_idx = SEL_W'((int'(cur_sel) + i) % NUM_OUT);
      if (chan_en[w_idx]) begin
        next_sel = w_idx;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_rr_sched.sv
// ============================================================================
//  Module   : demux_rr_sched
//  Brief    : Round-robin burst scheduler feeding a 1:NUM_OUT demux through a
//             one-word holding register. Define DEMUX_RR_SCHED_STATS_EN to
//             build the delivered-word counter on total_beats.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_OUT   = 4,
  parameter int BURST_LEN = 4,
  localparam int SEL_W    = sel_w(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OUT-1:0]        chan_en,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic [15:0]               total_beats
);

  localparam logic [BEAT_CNT_W:0] c_burst = (BEAT_CNT_W+1)'(BURST_LEN);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_buf_valid;
  logic [DATA_W-1:0]     r_buf_data;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;

  logic [SEL_W-1:0]      w_next_sel;
  logic                  w_found;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_room;
  logic                  w_burst_done;

  rr_next_sel #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_next_sel (
    .chan_en  (chan_en),
    .cur_sel  (r_sel),
    .next_sel (w_next_sel),
    .found    (w_found)
  );

  // Words accepted this burst (delivered plus buffered) must stay below BURST_LEN.
  assign w_room       = ({1'b0, r_beat_cnt} + {{BEAT_CNT_W{1'b0}}, r_buf_valid}) < c_burst;
  assign w_burst_done = ({1'b0, r_beat_cnt} == c_burst);
  assign w_out_fire   = r_buf_valid & out_ready[r_sel];
  assign w_in_fire    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|chan_en) w_state_nxt = SEEK;
      SEEK:    w_state_nxt = w_found ? XFER : IDLE;
      XFER:    if (!r_buf_valid && (w_burst_done || !chan_en[r_sel])) w_state_nxt = SEEK;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready         = (r_state == XFER) & chan_en[r_sel] & (~r_buf_valid | w_out_fire) & w_room;
    busy             = (r_state == XFER) | r_buf_valid;
    out_valid        = '0;
    out_valid[r_sel] = r_buf_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= SEL_W'(NUM_OUT - 1);
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (r_state == SEEK) begin
        r_beat_cnt <= '0;
        if (w_found) r_sel <= w_next_sel;
      end else if (w_out_fire) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_in_fire) begin
        r_buf_data  <= in_data;
        r_buf_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  assign sel      = r_sel;
  assign out_data = {NUM_OUT{r_buf_data}};

`ifdef DEMUX_RR_SCHED_STATS_EN
  logic [15:0] r_total_beats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total_beats <= '0;
    end else if (w_out_fire) begin
      r_total_beats <= r_total_beats + 16'd1;
    end
  end

  assign total_beats = r_total_beats;
`else
  assign total_beats = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
// ============================================================================
//  Module   : tb_demux_rr_sched
//  Brief    : Self-checking bench for demux_rr_sched: directed vector table,
//             hand-written corner sequences and randomized streams.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_rr_sched;

  localparam int DW = 8;
  localparam int NO = 4;
  localparam int BL = 4;
  localparam int DIS_EXP [8] = '{0, 0, 0, 1, 1, 1, 1, 2};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NO-1:0]     chan_en;
  logic [NO*DW-1:0]  out_data;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic [15:0]       total_beats;

  always #5 clk = ~clk;

  demux_rr_sched #(
    .DATA_W    (DW),
    .NUM_OUT   (NO),
    .BURST_LEN (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .chan_en     (chan_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sel         (sel),
    .busy        (busy),
    .total_beats (total_beats)
  );

  typedef struct {
    logic [3:0]      en;
    int              n;
    logic [7:0]      base;
    logic [3:0][1:0] bl_lane;
  } vec_t;

  vec_t        vecs [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          src_n, src_idx, total_del, budget, exp_tb;
  logic [7:0]  src_base;
  int          del_lane [$];
  logic [7:0]  del_data [$];
  logic [3:0]  prev_stall, prev_ov, seen_ov, en_r;
  logic [7:0]  prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level model: after reset, word j lands on the (j/BL)-th enabled lane in rotation.
  function automatic int exp_lane(input logic [3:0] en, input int j);
    int lst [$];
    for (int k = 0; k < NO; k++) if (en[k]) lst.push_back(k);
    return lst[(j / BL) % lst.size()];
  endfunction

  task automatic sample();
    if (in_valid && in_ready) src_idx++;
    seen_ov |= out_valid;
    if (out_valid != 0) chk("onehot_sel", 32'(out_valid), 32'(4'd1 << sel));
    chk("lane_replicate", out_data, {NO{out_data[7:0]}});
    if (prev_stall != 0) begin
      chk("stall_hold_valid", 32'(out_valid), 32'(prev_ov));
      chk("stall_hold_data", 32'(out_data[7:0]), 32'(prev_data));
    end
    for (int k = 0; k < NO; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        del_lane.push_back(k);
        del_data.push_back(out_data[k*DW +: DW]);
        total_del++;
      end
    end
    prev_stall = out_valid & ~out_ready;
    prev_ov    = out_valid;
    prev_data  = out_data[7:0];
  endtask

  task automatic drive(input logic [3:0] ordy, input bit send);
    out_ready = ordy;
    in_valid  = send && (src_idx < src_n);
    in_data   = src_base + 8'(src_idx);
  endtask

  task automatic cycle(input logic [3:0] ordy, input bit send);
    drive(ordy, send);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; chan_en = '0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    src_n = 0; src_idx = 0; total_del = 0;
    del_lane.delete(); del_data.delete();
    prev_stall = '0; seen_ov = '0;
  endtask

  task automatic start_stream(input int n, input logic [7:0] base);
    src_n = n; src_idx = 0; src_base = base;
    del_lane.delete(); del_data.delete();
    seen_ov = '0;
  endtask

  task automatic finish_stream(input int pv, input int pr);
    logic [3:0] ordy;
    int bud;
    bud = src_n * 50 + 100;
    while (del_lane.size() < src_n && bud > 0) begin
      for (int k = 0; k < NO; k++) ordy[k] = ($urandom_range(0, 99) < pr);
      cycle(ordy, ($urandom_range(0, 99) < pv));
      bud--;
    end
    chk("deliver_count", del_lane.size(), src_n);
  endtask

  task automatic chk_word(input int j, input int lane);
    if (j < del_lane.size()) begin
      chk("word_lane", del_lane[j], lane);
      chk("word_data", del_data[j], 8'(src_base + 8'(j)));
    end
  endtask

  initial begin
    vecs[0] = '{en: 4'b1111, n: 16, base: 8'h00, bl_lane: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{en: 4'b1010, n: 8,  base: 8'h40, bl_lane: {2'd3, 2'd1, 2'd3, 2'd1}};
    vecs[2] = '{en: 4'b0100, n: 8,  base: 8'h80, bl_lane: {2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[3] = '{en: 4'b1001, n: 16, base: 8'hC0, bl_lane: {2'd3, 2'd0, 2'd3, 2'd0}};

    // Reset state, held through clock edges.
    rst_n = 1'b0; chan_en = '0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    src_n = 0; src_idx = 0; src_base = '0; prev_stall = '0; seen_ov = '0; total_del = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, NO - 1);
    chk("rst_total_beats", total_beats, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      chan_en = vecs[v].en;
      start_stream(vecs[v].n, vecs[v].base);
      finish_stream(100, 100);
      for (int j = 0; j < vecs[v].n; j++) chk_word(j, int'(vecs[v].bl_lane[j / BL]));
      chk("stray_lane", seen_ov & ~vecs[v].en, 0);
    end

    // Backpressure on lane 0 with a word buffered.
    do_reset();
    chan_en = 4'hF;
    start_stream(4, 8'h10);
    budget = 20;
    while (src_idx == 0 && budget > 0) begin cycle(4'b0000, 1'b1); budget--; end
    chk("bp_accept", src_idx, 1);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0000, 1'b1);
      @(negedge clk);
      sample();
      chk("bp_valid", out_valid, 4'b0001);
      chk("bp_data", out_data[7:0], 8'h10);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    finish_stream(100, 100);
    for (int j = 0; j < 4; j++) chk_word(j, 0);

    // Disable the granted lane after two beats with a word still buffered.
    do_reset();
    chan_en = 4'hF;
    start_stream(8, 8'h20);
    budget = 30;
    while (del_lane.size() < 2 && budget > 0) begin cycle(4'hF, 1'b1); budget--; end
    chk("dis_two_beats", del_lane.size(), 2);
    chan_en = 4'b1110;
    drive(4'b0000, 1'b1);
    @(negedge clk);
    sample();
    chk("dis_hold_valid", out_valid, 4'b0001);
    chk("dis_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    finish_stream(100, 100);
    for (int j = 0; j < 8; j++) chk_word(j, DIS_EXP[j]);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    chan_en = 4'hF;
    start_stream(8, 8'h30);
    budget = 30;
    while (del_lane.size() < 2 && budget > 0) begin cycle(4'hF, 1'b1); budget--; end
    chk("arst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_sel", sel, NO - 1);
    chk("arst_total_beats", total_beats, 0);
    do_reset();
    chan_en = 4'hF;
    start_stream(4, 8'h50);
    finish_stream(100, 100);
    for (int j = 0; j < 4; j++) chk_word(j, 0);

    // Delivered-word statistics after 20 deliveries.
    do_reset();
    chan_en = 4'hF;
    start_stream(20, 8'h00);
    finish_stream(100, 100);
`ifdef DEMUX_RR_SCHED_STATS_EN
    exp_tb = 20;
`else
    exp_tb = 0;
`endif
    chk("total_beats_20", total_beats, exp_tb);

    // Randomized streams against the round-robin model.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      en_r    = 4'($urandom_range(1, 15));
      chan_en = en_r;
      start_stream(BL * $urandom_range(1, 5), 8'($urandom));
      finish_stream($urandom_range(30, 100), $urandom_range(20, 100));
      for (int j = 0; j < src_n; j++) chk_word(j, exp_lane(en_r, j));
      chk("rand_stray_lane", seen_ov & ~en_r, 0);
`ifdef DEMUX_RR_SCHED_STATS_EN
      exp_tb = total_del % 65536;
`else
      exp_tb = 0;
`endif
      chk("rand_total_beats", total_beats, exp_tb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
